// File: rtl/red_seq_if.sv
// ---------------------------------------------------------------------------
// red_seq_if
// Handshake / data bundle between a requester and the red_seq reduction unit.
//   start  : request a reduction (requester -> unit)
//   abort  : cancel an in-flight reduction (requester -> unit)
//   A, B   : 16-bit operands, captured when start is accepted
//   busy   : reduction in flight (unit -> requester)
//   done   : one-cycle result-valid pulse (unit -> requester)
//   red    : 16-bit reduction result, held until the next result
// ---------------------------------------------------------------------------
interface red_seq_if;
    logic        start;
    logic        abort;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] red;

    modport master (output start, abort, A, B, input busy, done, red);
    modport slave  (input start, abort, A, B, output busy, done, red);
endinterface

// File: rtl/red_seq.sv
// ---------------------------------------------------------------------------
// red_seq
// Sums the four signed bytes of A and B into a sign-extended 16-bit result,
// using one shared 4-bit adder slice with a registered carry:
//   AB1 (2 cycles): P1 = A[7:0]  + B[7:0]   (9-bit signed)
//   AB2 (2 cycles): P2 = A[15:8] + B[15:8]  (9-bit signed)
//   RED (3 cycles): P1 + P2 over nibbles 0..2 -> 10-bit signed sum
//   DONE(1 cycle) : done pulse, result visible on red
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : red_seq_if slave modport (start/abort/A/B in, busy/done/red out)
// ---------------------------------------------------------------------------
module red_seq (
    input  logic      clk,
    input  logic      rst_n,
    red_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AB1  = 3'd1,
        S_AB2  = 3'd2,
        S_RED  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic        carry_q, carry_d;
    logic [15:0] a_q,     a_d;
    logic [15:0] b_q,     b_d;
    logic [8:0]  p1_q,    p1_d;
    logic [8:0]  p2_q,    p2_d;
    logic [7:0]  acc_q,   acc_d;
    logic [15:0] red_q,   red_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic [3:0]  nib_a_s;
    logic [3:0]  nib_b_s;
    logic [4:0]  sum_s;
    logic        sign_s;

    // Operand select for the single shared 4-bit adder slice
    always_comb begin
        nib_a_s = 4'd0;
        nib_b_s = 4'd0;
        case (state_q)
            S_AB1: begin
                if (cnt_q == 2'd0) begin
                    nib_a_s = a_q[3:0];
                    nib_b_s = b_q[3:0];
                end else begin
                    nib_a_s = a_q[7:4];
                    nib_b_s = b_q[7:4];
                end
            end
            S_AB2: begin
                if (cnt_q == 2'd0) begin
                    nib_a_s = a_q[11:8];
                    nib_b_s = b_q[11:8];
                end else begin
                    nib_a_s = a_q[15:12];
                    nib_b_s = b_q[15:12];
                end
            end
            S_RED: begin
                case (cnt_q)
                    2'd0: begin
                        nib_a_s = p1_q[3:0];
                        nib_b_s = p2_q[3:0];
                    end
                    2'd1: begin
                        nib_a_s = p1_q[7:4];
                        nib_b_s = p2_q[7:4];
                    end
                    default: begin
                        // Top nibble: sign extension of the 9-bit partials
                        nib_a_s = {4{p1_q[8]}};
                        nib_b_s = {4{p2_q[8]}};
                    end
                endcase
            end
            default: begin
                nib_a_s = 4'd0;
                nib_b_s = 4'd0;
            end
        endcase
        sum_s  = {1'b0, nib_a_s} + {1'b0, nib_b_s} + {4'd0, carry_q};
        // Bit 8 of a signed byte sum: the two sign bits plus the carry out of bit 7
        sign_s = nib_a_s[3] ^ nib_b_s[3] ^ sum_s[4];
    end

    // Next-state, datapath update and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        acc_d   = acc_q;
        red_d   = red_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // abort has no meaning here; start alone decides
                if (bus.start) begin
                    state_d = S_AB1;
                    cnt_d   = 2'd0;
                    carry_d = 1'b0;
                    a_d     = bus.A;
                    b_d     = bus.B;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AB1: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                    carry_d = 1'b0;
                end else if (cnt_q == 2'd0) begin
                    p1_d[3:0] = sum_s[3:0];
                    carry_d   = sum_s[4];
                    cnt_d     = 2'd1;
                end else begin
                    p1_d[7:4] = sum_s[3:0];
                    p1_d[8]   = sign_s;
                    carry_d   = 1'b0;
                    cnt_d     = 2'd0;
                    state_d   = S_AB2;
                end
            end
            S_AB2: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                    carry_d = 1'b0;
                end else if (cnt_q == 2'd0) begin
                    p2_d[3:0] = sum_s[3:0];
                    carry_d   = sum_s[4];
                    cnt_d     = 2'd1;
                end else begin
                    p2_d[7:4] = sum_s[3:0];
                    p2_d[8]   = sign_s;
                    carry_d   = 1'b0;
                    cnt_d     = 2'd0;
                    state_d   = S_RED;
                end
            end
            S_RED: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                    carry_d = 1'b0;
                end else if (cnt_q == 2'd0) begin
                    acc_d[3:0] = sum_s[3:0];
                    carry_d    = sum_s[4];
                    cnt_d      = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    acc_d[7:4] = sum_s[3:0];
                    carry_d    = sum_s[4];
                    cnt_d      = 2'd2;
                end else begin
                    // 10-bit sum = {top nibble bits 1:0, low byte}, bit 9 is the sign
                    red_d   = {{6{sum_s[1]}}, sum_s[1:0], acc_q};
                    carry_d = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
                carry_d = 1'b0;
            end
        endcase
        busy_d = (state_d == S_AB1) || (state_d == S_AB2) || (state_d == S_RED);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            carry_q <= 1'b0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            p1_q    <= 9'd0;
            p2_q    <= 9'd0;
            acc_q   <= 8'd0;
            red_q   <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            acc_q   <= acc_d;
            red_q   <= red_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.red  = red_q;

endmodule

// File: tb/tb_red_seq.sv
// ---------------------------------------------------------------------------
// tb_red_seq
// Directed and randomized stimulus for red_seq. Expected results come from a
// plain signed-integer sum of the four operand bytes; timing expectations
// come from the fixed 7-cycle busy window followed by a 1-cycle done pulse.
// ---------------------------------------------------------------------------
module tb_red_seq;

    logic clk = 1'b0;
    logic rst_n;
    red_seq_if bus ();

    red_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [15:0] exp_red;

    // Free-running cycle counter for latency / spacing measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference: signed sum of the four bytes, sign-extended to 16 bits
    function automatic logic [15:0] ref_red(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a[7:0])) + int'($signed(b[7:0]))
          + int'($signed(a[15:8])) + int'($signed(b[15:8]));
        return s[15:0];
    endfunction

    // Issue start with a/b; scramble operands during the busy window, optionally
    // pulse start at busy cycle poke_cyc and abort at busy cycle abort_cyc.
    // Returns in the done cycle (or one cycle after an abort took effect).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int poke_cyc, input int abort_cyc,
                          input bit idle_abort, output int done_cyc);
        logic [15:0] r;
        r          = ref_red(a, b);
        done_cyc   = -1;
        bus.A      = a;
        bus.B      = b;
        bus.start  = 1'b1;
        bus.abort  = idle_abort;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            check("busy_high", bus.busy, 32'd1);
            check("done_low", bus.done, 32'd0);
            check("red_hold", bus.red, exp_red);
            bus.A     = 16'($urandom);
            bus.B     = 16'($urandom);
            bus.start = (i == poke_cyc);
            bus.abort = (i == abort_cyc);
            @(negedge clk);
            if (i == abort_cyc) begin
                bus.start = 1'b0;
                bus.abort = 1'b0;
                check("abort_busy", bus.busy, 32'd0);
                check("abort_done", bus.done, 32'd0);
                check("abort_red", bus.red, exp_red);
                @(negedge clk);
                check("abort_nodone", bus.done, 32'd0);
                check("abort_idle", bus.busy, 32'd0);
                return;
            end
        end
        bus.start = 1'b0;
        check("done_pulse", bus.done, 32'd1);
        check("done_busy", bus.busy, 32'd0);
        check("red_result", bus.red, r);
        exp_red  = r;
        done_cyc = cyc;
    endtask

    // One cycle after DONE with start low: back in IDLE, result held
    task automatic settle();
        @(negedge clk);
        check("idle_done", bus.done, 32'd0);
        check("idle_busy", bus.busy, 32'd0);
        check("idle_red", bus.red, exp_red);
    endtask

    initial begin
        int d1;
        int d2;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.A     = 16'd0;
        bus.B     = 16'd0;
        exp_red   = 16'd0;

        // Reset holds everything at zero even with start asserted
        @(negedge clk);
        bus.A     = 16'h1234;
        bus.start = 1'b1;
        @(negedge clk);
        check("rst_busy", bus.busy, 32'd0);
        check("rst_done", bus.done, 32'd0);
        check("rst_red", bus.red, 32'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("idle_busy0", bus.busy, 32'd0);

        // Basic run
        run_op(16'h0101, 16'h0101, -1, -1, 1'b0, d1);
        check("basic_red", bus.red, 32'h0004);
        settle();

        // Extremes
        run_op(16'h8080, 16'h8080, -1, -1, 1'b0, d1);
        check("min_red", bus.red, 32'h0000FE00);
        settle();
        run_op(16'h7F7F, 16'h7F7F, -1, -1, 1'b0, d1);
        check("max_red", bus.red, 32'h01FC);
        settle();

        // Back-to-back with start seen in DONE
        run_op(16'h00FF, 16'h0001, -1, -1, 1'b0, d1);
        check("b2b_red1", bus.red, 32'h0000);
        run_op(16'h0302, 16'h0100, -1, -1, 1'b0, d2);
        check("b2b_red2", bus.red, 32'h0006);
        check("b2b_gap", d2 - d1, 32'd8);
        settle();

        // start during AB2 ignored
        run_op(16'h1234, 16'h5678, 2, -1, 1'b0, d1);
        settle();

        // abort in RED cycle 2 after a 0x0004 result
        run_op(16'h0101, 16'h0101, -1, -1, 1'b0, d1);
        settle();
        run_op(16'h1111, 16'h2222, -1, 5, 1'b0, d1);
        check("abort_keep4", bus.red, 32'h0004);

        // abort and start together while busy: abort wins
        run_op(16'h4321, 16'h8765, 3, 3, 1'b0, d1);

        // abort in IDLE alongside start: start wins
        run_op(16'hFFFE, 16'h0203, -1, -1, 1'b1, d1);
        settle();

        // abort alone in IDLE does nothing
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("idle_abort_busy", bus.busy, 32'd0);
        check("idle_abort_red", bus.red, exp_red);

        // Reset during AB1, then a normal run
        bus.A     = 16'h2222;
        bus.B     = 16'h3333;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("midrst_busy", bus.busy, 32'd0);
        check("midrst_done", bus.done, 32'd0);
        check("midrst_red", bus.red, 32'd0);
        rst_n   = 1'b1;
        exp_red = 16'd0;
        @(negedge clk);
        check("midrst_nodone", bus.done, 32'd0);
        run_op(16'h0A0B, 16'hF0F1, -1, -1, 1'b0, d1);
        settle();

        // Randomized runs with stray starts, aborts and back-to-back issue
        for (int n = 0; n < 40; n++) begin
            int poke;
            int abrt;
            poke = int'($urandom_range(0, 9));
            abrt = int'($urandom_range(0, 20));
            if (poke > 6) poke = -1;
            if (abrt > 6) abrt = -1;
            run_op(16'($urandom), 16'($urandom), poke, abrt, 1'($urandom), d1);
            if (d1 >= 0 && $urandom_range(0, 2) != 0) settle();
        end
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/red_seq.md
RED_SEQ -- requirements
Module: red_seq

Interface
REQ-001: clk  input  1  single system clock; all state updates on rising edge.
REQ-002: rst_n  input  1  synchronous reset, active-low, sampled on rising clk.
REQ-003: start  input  1  request a reduction; sampled only in IDLE or DONE.
REQ-004: abort  input  1  cancel an in-flight reduction; synchronous.
REQ-005: A  input  16  operand A, captured on start acceptance.
REQ-006: B  input  16  operand B, captured on start acceptance.
REQ-007: busy  output  1  high while a reduction is in flight (AB1, AB2, RED states).
REQ-008: done  output  1  one-cycle pulse marking the result as valid.
REQ-009: red  output  16  reduction result, held until the next result is written.

Function
REQ-010: Arithmetic SHALL be red = SEXT16(SEXT9(A[7:0]) + SEXT9(B[7:0]) + SEXT9(A[15:8]) + SEXT9(B[15:8])), with all bytes signed.
REQ-011: Computation SHALL use exactly one shared 4-bit adder slice with a registered carry, applied nibble-serially; no wider adder is permitted.
REQ-012: The FSM SHALL have these states: IDLE, AB1, AB2, RED, DONE.
REQ-013: A start seen high in IDLE or DONE SHALL latch A and B into internal registers and go to AB1.
REQ-014: AB1 SHALL last 2 cycles, computing nibble 0 and then nibble 1 of A[7:0]+B[7:0]; the carry-in of nibble 0 SHALL be 0; the result SHALL be a 9-bit signed partial P1.
REQ-015: AB2 SHALL last 2 cycles, computing P2 = A[15:8]+B[15:8] in the same way; the carry register SHALL be cleared on entry.
REQ-016: RED SHALL last 3 cycles, adding P1 and P2 over nibbles 0, 1 and 2; nibble 2 SHALL use the sign-extended bit 8 of each partial; the carry SHALL be cleared on entry.
REQ-017: On the RED-to-DONE transition, red SHALL be loaded with the 10-bit sum sign-extended to 16 bits.
REQ-018: DONE SHALL last 1 cycle with done=1, then return to IDLE, unless start is high, in which case it goes to AB1 (back-to-back).
REQ-019: Latency SHALL be fixed: for start accepted at edge k, done=1 during the cycle following edge k+7.
REQ-020: busy SHALL be 1 exactly in AB1, AB2 and RED.
REQ-021: done SHALL be 1 exactly in DONE.
REQ-022: start while busy SHALL be ignored, with no effect on latched operands or sequence.
REQ-023: abort high in AB1, AB2 or RED SHALL return the FSM to IDLE at the next edge, leave red unchanged and emit no done pulse.
REQ-024: abort in IDLE or DONE SHALL have no effect, and start SHALL take priority there.
REQ-025: When abort and start are both high while busy, abort SHALL win and start SHALL be ignored.
REQ-026: Operand changes on A or B after acceptance SHALL NOT affect the in-flight result.
REQ-027: Partial sums SHALL never saturate; a 10-bit range (-512..+508) always suffices.

Reset
REQ-028: With rst_n=0 at a rising edge, the FSM SHALL go to IDLE and busy, done, red, P1, P2, the carry and the latched operands SHALL all clear to 0.
REQ-029: Reset SHALL override start and abort in every state, including mid-operation; no done pulse SHALL follow a mid-operation reset.
REQ-030: The first start SHALL be accepted at the first edge with rst_n=1 and start=1.

Verification
REQ-031: A=0x0101, B=0x0101, start for 1 cycle -> busy high for 7 cycles, then done pulse, red=0x0004.
REQ-032: A=0x8080, B=0x8080 -> red=0xFE00 (-512); A=0x7F7F, B=0x7F7F -> red=0x01FC (+508).
REQ-033: Back-to-back runs A=0x00FF, B=0x0001 (result 0x0000) then start held in DONE with A=0x0302, B=0x0100 (result 0x0006) -> two done pulses exactly 8 cycles apart, red correct after each.
REQ-034: start pulsed during AB2 with different operands -> ignored; result matches the first operands; done occurs once.
REQ-035: abort in RED cycle 2 after a prior result of 0x0004 -> IDLE next cycle, red stays 0x0004, no done pulse.
REQ-036: rst_n=0 during AB1 -> all outputs 0 next cycle; no done pulse; a new start afterwards completes normally.
